// File: rtl/a25_wishbone_pbuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : a25_wb_pkg
//  Description : Shared definitions for the Amber wishbone posted-write
//                buffer: read FSM state encoding and width derivations.
//  Revision    : 1.0 - initial release
// ============================================================================
package a25_wb_pkg;

  // Read sequencing states: IDLE = 0, RD_WAIT = 1
  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_t;

  // Byte-enable width for a given data width
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  // Level counter width able to hold 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/a25_wishbone_pbuf_if.sv
`default_nettype none
// ============================================================================
//  Module      : a25_wishbone_pbuf_if
//  Description : Request/response bundle used on both sides of the posted
//                write buffer. On the core side the buffer is the slave
//                (ack = completion, rdata_valid = read completion); on the
//                arbiter side it is the master (ack = request accepted).
//  Revision    : 1.0 - initial release
// ============================================================================
interface a25_wishbone_pbuf_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              valid;
  logic              write;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;

  modport master (
    output valid, write, wdata, be, addr,
    input  ack, rdata, rdata_valid
  );

  modport slave (
    input  valid, write, wdata, be, addr,
    output ack, rdata, rdata_valid
  );
endinterface
`default_nettype wire

// File: rtl/a25_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : a25_sync_fifo
//  Description : Synchronous circular-buffer FIFO with registered occupancy
//                count, full/empty flags and synchronous active-high reset.
//                DEPTH must be a power of two so pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module a25_sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic [W-1:0]     i_wdata,
  output logic      [W-1:0]     o_rdata,
  output logic      [CNT_W-1:0] o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/a25_wishbone_pbuf.sv
`default_nettype none
// ============================================================================
//  Module      : a25_wishbone_pbuf
//  Description : Posted-write buffer between an Amber core port and the
//                wishbone arbiter. Writes are acked on entry to a FIFO;
//                reads wait for the FIFO to drain, then go out unbuffered
//                and are acked when read data returns.
//  Revision    : 1.0 - initial release
// ============================================================================
module a25_wishbone_pbuf
  import a25_wb_pkg::*;
#(
  parameter  int DATA_W = 128,
  parameter  int ADDR_W = 32,
  parameter  int DEPTH  = 4,
  localparam int BE_W   = be_width(DATA_W),
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  wire logic     i_clk,
  input  wire logic     i_rst,
  a25_wishbone_pbuf_if.slave  io_core,
  a25_wishbone_pbuf_if.master io_bus,
  output logic [CNT_W-1:0] o_level,
  output logic             o_empty
);

  localparam int ENTRY_W = ADDR_W + BE_W + DATA_W;

  rd_state_t r_state;
  rd_state_t w_state_nxt;

  logic [ENTRY_W-1:0] w_head;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [BE_W-1:0]    w_head_be;
  logic [DATA_W-1:0]  w_head_wdata;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_level_zero;

  logic w_wr_req;
  logic w_rd_req;
  logic w_push;
  logic w_bypass;
  logic w_pop;
  logic w_rd_done;

  logic              w_valid;
  logic              w_bus_write;
  logic [ADDR_W-1:0] w_bus_addr;
  logic [BE_W-1:0]   w_bus_be;
  logic [DATA_W-1:0] w_bus_wdata;

  assign w_head_addr  = w_head[DATA_W+BE_W +: ADDR_W];
  assign w_head_be    = w_head[DATA_W +: BE_W];
  assign w_head_wdata = w_head[0 +: DATA_W];

  assign w_wr_req = io_core.valid & io_core.write;
  assign w_rd_req = io_core.valid & ~io_core.write;

  // Writes are taken whenever there is room; none while a read is in flight
  assign w_push = w_wr_req & ~w_full & ~i_rst & (r_state == RD_IDLE);

  // A write arriving at an empty queue is shown on the bus directly; if the
  // arbiter takes it that same cycle it never needs to occupy an entry.
  assign w_bypass = w_push & w_level_zero & io_bus.ack;
  assign w_pop    = w_valid & io_bus.ack & ~w_level_zero;

  assign w_rd_done = (r_state == RD_WAIT) & io_bus.rdata_valid & ~i_rst;

  a25_sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push & ~w_bypass),
    .i_pop   (w_pop),
    .i_wdata ({io_core.addr, io_core.be, io_core.wdata}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_level_zero)
  );

  // Read FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read FSM next state and arbiter-side request muxing
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_bus_write = io_core.write;
    w_bus_addr  = io_core.addr;
    w_bus_be    = io_core.be;
    w_bus_wdata = io_core.wdata;

    case (r_state)
      RD_IDLE: begin
        if (w_rd_req && w_level_zero && io_bus.ack) begin
          w_state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (io_bus.rdata_valid) begin
          w_state_nxt = RD_IDLE;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase

    if (!w_level_zero) begin
      // Queued writes always go first, head of queue on the bus
      w_valid     = 1'b1;
      w_bus_write = 1'b1;
      w_bus_addr  = w_head_addr;
      w_bus_be    = w_head_be;
      w_bus_wdata = w_head_wdata;
    end else if (r_state == RD_IDLE) begin
      if (w_wr_req) begin
        w_valid = 1'b1;
      end else if (w_rd_req) begin
        w_valid     = 1'b1;
        w_bus_write = 1'b0;
        w_bus_be    = '1;
      end
    end

    if (i_rst) begin
      w_valid = 1'b0;
    end
  end

  assign io_bus.valid = w_valid;
  assign io_bus.write = w_bus_write;
  assign io_bus.addr  = w_bus_addr;
  assign io_bus.be    = w_bus_be;
  assign io_bus.wdata = w_bus_wdata;

  assign io_core.ack         = w_push | w_rd_done;
  assign io_core.rdata       = io_bus.rdata;
  assign io_core.rdata_valid = w_rd_done;

  assign o_level = w_count;
  assign o_empty = w_level_zero & (r_state == RD_IDLE);

endmodule
`default_nettype wire
